// File: rtl/elevator_display_formatter_pkg.sv
// Shared glyph codes, glyph indices, FSM and direction encodings for the
// elevator display formatter. Glyphs are 7-bit {g,f,e,d,c,b,a}, active-low.
package elev_disp_pkg;

  localparam logic [6:0] CH_0     = 7'b1000000;
  localparam logic [6:0] CH_1     = 7'b1111001;
  localparam logic [6:0] CH_2     = 7'b0100100;
  localparam logic [6:0] CH_3     = 7'b0110000;
  localparam logic [6:0] CH_4     = 7'b0011001;
  localparam logic [6:0] CH_5     = 7'b0010010;
  localparam logic [6:0] CH_6     = 7'b0000010;
  localparam logic [6:0] CH_7     = 7'b1111000;
  localparam logic [6:0] CH_F     = 7'b0001110;
  localparam logic [6:0] CH_O     = 7'b1000000;
  localparam logic [6:0] CH_P     = 7'b0001100;
  localparam logic [6:0] CH_C     = 7'b1000110;
  localparam logic [6:0] CH_L     = 7'b1000111;
  localparam logic [6:0] CH_UP    = 7'b1111110;
  localparam logic [6:0] CH_DN    = 7'b1110111;
  localparam logic [6:0] CH_IDLE  = 7'b0111111;
  localparam logic [6:0] CH_BLANK = 7'b1111111;

  // 'O' shares the glyph of digit 0, which frees a slot so 16 glyphs fit in 4 bits.
  typedef enum logic [3:0] {
    CI_0     = 4'd0,
    CI_1     = 4'd1,
    CI_2     = 4'd2,
    CI_3     = 4'd3,
    CI_4     = 4'd4,
    CI_5     = 4'd5,
    CI_6     = 4'd6,
    CI_7     = 4'd7,
    CI_F     = 4'd8,
    CI_P     = 4'd9,
    CI_C     = 4'd10,
    CI_L     = 4'd11,
    CI_UP    = 4'd12,
    CI_DN    = 4'd13,
    CI_IDLE  = 4'd14,
    CI_BLANK = 4'd15
  } char_idx_e;

  localparam char_idx_e CI_O = CI_0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_ARRIVE = 2'd2
  } state_e;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DN   = 2'b10;

endpackage

// File: rtl/elevator_display_formatter_if.sv
// Elevator status inputs and per-digit active-low segment outputs.
// master drives status and observes segments; slave is the formatter.
interface elev_disp_if;
  logic [2:0] floor;
  logic [1:0] dir;
  logic       moving;
  logic       door_open;
  logic       req_pending;
  logic [7:0] seg_a;
  logic [7:0] seg_b;
  logic [7:0] seg_c;
  logic [7:0] seg_d;
  logic [7:0] seg_e;
  logic [7:0] seg_f;
  logic [7:0] seg_g;
  logic [7:0] seg_p;

  modport master (
    output floor, dir, moving, door_open, req_pending,
    input  seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_p
  );

  modport slave (
    input  floor, dir, moving, door_open, req_pending,
    output seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_p
  );
endinterface

// File: rtl/elevator_display_formatter_seg_char_rom.sv
// Combinational glyph ROM: 4-bit glyph index to 7-bit active-low segment code.
module seg_char_rom
  import elev_disp_pkg::*;
(
  input  char_idx_e  idx,
  output logic [6:0] code
);

  always_comb begin
    code = CH_BLANK;
    case (idx)
      CI_0:    code = CH_0;
      CI_1:    code = CH_1;
      CI_2:    code = CH_2;
      CI_3:    code = CH_3;
      CI_4:    code = CH_4;
      CI_5:    code = CH_5;
      CI_6:    code = CH_6;
      CI_7:    code = CH_7;
      CI_F:    code = CH_F;
      CI_P:    code = CH_P;
      CI_C:    code = CH_C;
      CI_L:    code = CH_L;
      CI_UP:   code = CH_UP;
      CI_DN:   code = CH_DN;
      CI_IDLE: code = CH_IDLE;
      default: code = CH_BLANK;
    endcase
  end

endmodule

// File: rtl/elevator_display_formatter.sv
// Elevator status to 8-digit seven-segment formatter with blinking arrow and arrival flash.
// Outputs registered: 1 cycle from inputs, 2 cycles from a state-changing input; no backpressure.
module elevator_display_formatter #(
  parameter int BLINK_DIV     = 25000000,
  parameter int FLASH_TOGGLES = 6
) (
  input logic        clk,
  input logic        reset,
  elev_disp_if.slave bus
);
  import elev_disp_pkg::*;

  localparam int             PW        = $clog2(BLINK_DIV);
  localparam logic [PW-1:0]  PRESC_TOP = PW'(BLINK_DIV - 1);
  localparam logic [3:0]     FLASH_N   = 4'(FLASH_TOGGLES);

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      flash_q, flash_d;
  logic            blink_q, blink_d;
  logic            tick;

  char_idx_e       idx_d6, idx_d4, idx_d1, idx_d0;
  logic [6:0]      code_d6, code_d4, code_d1, code_d0;
  logic [7:0][6:0] digit_code;
  logic [6:0][7:0] seg_q, seg_d;
  logic [7:0]      p_q, p_d;

  assign tick = (presc_q == PRESC_TOP);

  always_comb begin
    state_d = state_q;
    flash_d = flash_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.moving) state_d = ST_MOVE;
      end
      ST_MOVE: begin
        if (!bus.moving) begin
          state_d = ST_ARRIVE;
          flash_d = FLASH_N;
        end
      end
      ST_ARRIVE: begin
        // Motion resuming overrides the final flash tick.
        if (bus.moving) begin
          state_d = ST_MOVE;
        end else if (tick) begin
          if (flash_q == 4'd1) state_d = ST_IDLE;
          else                 flash_d = flash_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    presc_d = tick ? '0 : presc_q + 1'b1;
    blink_d = tick ? ~blink_q : blink_q;
    // Each effect starts visible with a full half-period.
    if (state_d != state_q) begin
      presc_d = '0;
      blink_d = 1'b1;
    end
  end

  always_comb begin
    idx_d6 = char_idx_e'({1'b0, bus.floor});
    case (bus.dir)
      DIR_UP:   idx_d4 = CI_UP;
      DIR_DN:   idx_d4 = CI_DN;
      DIR_IDLE: idx_d4 = CI_IDLE;
      default:  idx_d4 = CI_IDLE;
    endcase
    idx_d1 = bus.door_open ? CI_O : CI_C;
    idx_d0 = bus.door_open ? CI_P : CI_L;
    if (!blink_q && state_q == ST_MOVE)   idx_d4 = CI_BLANK;
    if (!blink_q && state_q == ST_ARRIVE) idx_d6 = CI_BLANK;
  end

  seg_char_rom u_rom_d6 (.idx(idx_d6), .code(code_d6));
  seg_char_rom u_rom_d4 (.idx(idx_d4), .code(code_d4));
  seg_char_rom u_rom_d1 (.idx(idx_d1), .code(code_d1));
  seg_char_rom u_rom_d0 (.idx(idx_d0), .code(code_d0));

  always_comb begin
    digit_code[7] = CH_F;
    digit_code[6] = code_d6;
    digit_code[5] = CH_BLANK;
    digit_code[4] = code_d4;
    digit_code[3] = CH_BLANK;
    digit_code[2] = CH_BLANK;
    digit_code[1] = code_d1;
    digit_code[0] = code_d0;

    // Transpose digit-major glyphs into segment-major buses.
    seg_d = '1;
    for (int s = 0; s < 7; s++) begin
      for (int i = 0; i < 8; i++) begin
        seg_d[s][i] = digit_code[i][s];
      end
    end
    p_d    = 8'hFF;
    p_d[0] = ~bus.req_pending;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      flash_q <= '0;
      blink_q <= 1'b1;
      seg_q   <= '1;
      p_q     <= '1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      flash_q <= flash_d;
      blink_q <= blink_d;
      seg_q   <= seg_d;
      p_q     <= p_d;
    end
  end

  assign bus.seg_a = seg_q[0];
  assign bus.seg_b = seg_q[1];
  assign bus.seg_c = seg_q[2];
  assign bus.seg_d = seg_q[3];
  assign bus.seg_e = seg_q[4];
  assign bus.seg_f = seg_q[5];
  assign bus.seg_g = seg_q[6];
  assign bus.seg_p = p_q;

endmodule

// File: tb/tb_elevator_display_formatter.sv
// Scoreboard bench: stimulus pushes expected segment buses from a timeline model; a monitor pops and compares.
module tb_elevator_display_formatter;

  localparam int D = 4;
  localparam int F = 4;

  logic clk;
  logic reset;
  elev_disp_if bus ();

  elevator_display_formatter #(
    .BLINK_DIV     (D),
    .FLASH_TOGGLES (F)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;
  int n_cyc  = 0;

  // Model: which phase of the display the car is in, and how long it has been there.
  int m_phase = 0;  // 0 = steady, 1 = moving, 2 = arrival flash
  int m_age   = 0;

  function automatic logic [6:0] digit_glyph(input int n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      default: return 7'b1111000;
    endcase
  endfunction

  function automatic logic [63:0] model_out(input logic rst, input logic mv,
      input logic [1:0] dir, input logic [2:0] fl, input logic door, input logic req);
    logic [6:0] g [8];
    logic [63:0] v;
    bit visible;
    if (rst) return {64{1'b1}};
    visible = ((m_age / D) % 2) == 0;
    g[7] = 7'b0001110;
    g[6] = (m_phase == 2 && !visible) ? 7'b1111111 : digit_glyph(int'(fl));
    g[5] = 7'b1111111;
    g[4] = (dir == 2'b01) ? 7'b1111110 : (dir == 2'b10) ? 7'b1110111 : 7'b0111111;
    if (m_phase == 1 && !visible) g[4] = 7'b1111111;
    g[3] = 7'b1111111;
    g[2] = 7'b1111111;
    g[1] = door ? 7'b1000000 : 7'b1000110;
    g[0] = door ? 7'b0001100 : 7'b1000111;
    v = '1;
    for (int s = 0; s < 7; s++)
      for (int i = 0; i < 8; i++)
        v[s*8 + i] = g[i][s];
    v[56] = ~req;
    return v;
  endfunction

  task automatic model_step(input logic rst, input logic mv);
    int nxt;
    if (rst) begin
      m_phase = 0;
      m_age   = 0;
      return;
    end
    nxt = m_phase;
    if (m_phase == 0 && mv)       nxt = 1;
    else if (m_phase == 1 && !mv) nxt = 2;
    else if (m_phase == 2) begin
      if (mv)                     nxt = 1;
      else if (m_age == F*D - 1)  nxt = 0;
    end
    if (nxt != m_phase) m_age = 0;
    else                m_age++;
    m_phase = nxt;
  endtask

  task automatic cyc(input logic rst, input logic mv, input logic [1:0] dir,
      input logic [2:0] fl, input logic door, input logic req, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset           = rst;
      bus.moving      = mv;
      bus.dir         = dir;
      bus.floor       = fl;
      bus.door_open   = door;
      bus.req_pending = req;
      exp_q.push_back(model_out(rst, mv, dir, fl, door, req));
      model_step(rst, mv);
    end
  endtask

  initial begin : monitor
    logic [63:0] got, exp;
    forever begin
      @(posedge clk);
      #1;
      n_cyc++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {bus.seg_p, bus.seg_g, bus.seg_f, bus.seg_e, bus.seg_d,
               bus.seg_c, bus.seg_b, bus.seg_a};
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL segs cycle=%0d got=%h exp=%h (p,g,f,e,d,c,b,a)", n_cyc, got, exp);
      end
    end
  end

  initial begin : stim
    logic mv, door, req, rst;
    logic [1:0] dir;
    logic [2:0] fl;
    reset           = 1'b1;
    bus.moving      = 1'b0;
    bus.dir         = 2'b00;
    bus.floor       = 3'd0;
    bus.door_open   = 1'b0;
    bus.req_pending = 1'b0;

    cyc(1, 0, 2'b00, 3'd5, 1, 0, 3);
    cyc(0, 0, 2'b00, 3'd5, 1, 0, 3);
    cyc(0, 0, 2'b00, 3'd5, 1, 1, 2);
    cyc(0, 1, 2'b01, 3'd5, 1, 1, 20);
    cyc(0, 0, 2'b01, 3'd3, 0, 0, 20);
    cyc(0, 0, 2'b00, 3'd3, 0, 0, 3);
    cyc(0, 1, 2'b10, 3'd3, 0, 0, 10);
    cyc(0, 0, 2'b10, 3'd2, 0, 0, 6);
    cyc(0, 1, 2'b10, 3'd2, 0, 0, 8);
    cyc(0, 0, 2'b10, 3'd1, 0, 1, 16);
    cyc(0, 1, 2'b01, 3'd1, 0, 1, 6);
    cyc(0, 1, 2'b11, 3'd7, 0, 1, 12);
    cyc(0, 1, 2'b11, 3'd7, 1, 1, 2);
    cyc(0, 1, 2'b11, 3'd7, 0, 0, 2);
    cyc(0, 0, 2'b00, 3'd6, 0, 0, 7);
    cyc(1, 0, 2'b00, 3'd6, 0, 0, 1);
    cyc(0, 0, 2'b00, 3'd6, 0, 0, 10);

    mv = 1'b0;
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 2) != 0) mv = ~mv;
      dir  = 2'($urandom_range(0, 3));
      fl   = 3'($urandom_range(0, 7));
      door = 1'($urandom_range(0, 1));
      req  = 1'($urandom_range(0, 1));
      rst  = ($urandom_range(0, 19) == 0);
      cyc(rst, mv, dir, fl, door, req, int'($urandom_range(1, 22)));
    end

    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain pending=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
